spi_io_ctrl: RTL and testbench
==============================

Name: spi_io_ctrl

Overview:
- Memory-mapped SPI master controller for the processor's IO window (byte addresses 0x800 and above).
- Decodes byte stores and loads from the CPU into register accesses.
- Sequences the external SPI port (spi_clk, mosi, miso, spi_addr[2:0]) as a mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit master.
- Reports completion to the micro-code matrix through irq_o.

Parameters:
- CLK_DIV, 4, SPI half-period in clk_i cycles (legal range 2..255).
- DEV_BITS, 3, width of the spi_addr device-select field.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  asynchronous, active-low reset
- io_wr_ni  input  1  IO write strobe, active low, one clk_i cycle per store
- io_rd_i  input  1  IO read strobe, active high, one cycle per load
- reg_addr_i  input  2  register select: 0 DATA, 1 CTRL, 2 STATUS, 3 reserved
- data_i  input  8  write data (CPU rsb[7:0])
- rd_data_o  output  8  registered read data
- irq_o  output  1  level interrupt: rx_valid AND CTRL.ie
- busy_o  output  1  transfer in progress
- spi_clk  output  1  SPI serial clock
- mosi  output  1  serial data to slave
- miso  input  1  serial data from slave
- spi_addr  output  DEV_BITS  device select, decoded to SS lines by external glue; 0 = no device

Behaviour:
- Reset (asynchronous, active low): all outputs 0; CTRL=0x00; rx byte 0x00; rx_valid=0; overrun=0; state IDLE. A reset asserted mid-transfer takes effect immediately: spi_clk=0, spi_addr=0, mosi=0, and the transfer is aborted with no rx_valid.
- CTRL register (read/write):
  - [2:0] dev: SPI device number.
  - [3] ie: interrupt enable.
  - [7:4] reserved: written values ignored, read as 0.
- STATUS register (read-only):
  - [0] busy.
  - [1] rx_valid.
  - [2] overrun.
  - Other bits read as 0.
  - A write to STATUS clears overrun.
- DATA write:
  - In IDLE with CTRL.dev != 0: latch data_i into the shifter, clear rx_valid, go to SETUP on the next edge.
  - With dev == 0: the write is ignored and overrun is set.
  - While busy: the write is ignored, overrun is set, and the shifter is not disturbed.
- DATA read: rd_data_o = rx byte. The read clears rx_valid.
- Read timing: rd_data_o is updated on the clock edge where io_rd_i=1 (one-cycle latency). It holds its value otherwise.
- FSM IDLE -> SETUP -> XFER -> HOLD -> IDLE. A half-period tick fires every CLK_DIV cycles; the divider counter restarts on entry to SETUP.
  - SETUP (1 half-period): spi_addr = dev; mosi = bit7; spi_clk = 0.
  - XFER (16 half-periods, 3-bit bit counter):
    - Rising tick: spi_clk goes to 1 and miso is sampled into the shifter LSB.
    - Falling tick: spi_clk goes to 0 and mosi shifts to the next bit.
    - After the 8th falling tick, go to HOLD. mosi holds its last value.
  - HOLD (1 half-period): spi_clk = 0; spi_addr is still asserted.
  - On exit from HOLD: spi_addr = 0; rx byte = shifter; rx_valid = 1; busy_o = 0.
- busy_o is 1 in SETUP, XFER and HOLD only. It rises the cycle after the accepted write. It falls 18*CLK_DIV cycles later, which is 72 cycles at the default.
- Simultaneous DATA read and transfer completion: set wins, so rx_valid = 1 afterward. The read returns the old rx byte.
- Simultaneous STATUS write and an overrun-causing DATA write cannot occur: there is one register address per cycle.
- CTRL written while busy: the new dev value takes effect from the next transfer only. spi_addr for the current transfer is latched at SETUP entry.
- spi_clk, mosi and spi_addr are driven directly from flops (glitch-free).

Decomposition:
- Package spi_io_pkg:
  - SpiState enum (IDLE, SETUP, XFER, HOLD).
  - Register offsets REG_DATA=0, REG_CTRL=1, REG_STATUS=2.
  - STATUS bit indices.
  - CTRL field positions.
- Sub-module spi_tick_gen: parameterised CLK_DIV counter with a synchronous restart input and a one-cycle tick_o output. Bit sequencing and the register file stay in spi_io_ctrl.

Test Plan:
- Basic transfer:
  - Stimulus: CTRL=0x01; DATA write 0xA5; slave echoes 0x3C on miso.
  - Required: mosi bits 1,0,1,0,0,1,0,1 each stable at a rising edge; spi_addr=1 for exactly 72 cycles; STATUS=0x02 after completion; DATA read returns 0x3C; rx_valid then 0.
- Interrupt:
  - Stimulus: CTRL=0x0A; transfer 0xFF.
  - Required: irq_o rises with rx_valid; spi_addr=2 during the transfer; irq_o drops the cycle after a DATA read.
- Overrun while busy:
  - Stimulus: DATA write 0x55, then DATA write 0x99 at cycle 10.
  - Required: the transfer still shifts 0x55; STATUS.overrun=1; a STATUS write clears it.
- dev=0:
  - Stimulus: CTRL=0x00; DATA write 0x12.
  - Required: no spi_clk edges; busy_o stays 0; overrun=1.
- Reset mid-transfer:
  - Stimulus: reset_i low at cycle 30 of a transfer.
  - Required: spi_clk, mosi, spi_addr and busy_o are 0 asynchronously; a new transfer after release completes normally.
- Simultaneous events:
  - Stimulus: a DATA read in the exact completion cycle.
  - Required: the read returns the prior byte; rx_valid=1 afterward. Repeat with CLK_DIV=2 to confirm 36-cycle busy.

Source files
------------

// File: rtl/spi_io_pkg.sv
// Shared constants for the SPI IO controller: FSM encodings, register map and field positions.
// Constants only: no latency or backpressure of its own.
package spi_io_pkg;

  typedef logic [1:0] spi_state_t;

  localparam spi_state_t ST_IDLE  = 2'd0;
  localparam spi_state_t ST_SETUP = 2'd1;
  localparam spi_state_t ST_XFER  = 2'd2;
  localparam spi_state_t ST_HOLD  = 2'd3;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_RXV  = 1;
  localparam int STAT_OVR  = 2;

  localparam int CTRL_DEV_LSB = 0;
  localparam int CTRL_IE      = 3;

  function automatic logic [7:0] status_byte(input logic busy, input logic rxv, input logic ovr);
    logic [7:0] s;
    s            = '0;
    s[STAT_BUSY] = busy;
    s[STAT_RXV]  = rxv;
    s[STAT_OVR]  = ovr;
    return s;
  endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: one-cycle tick_o every CLK_DIV cycles, first tick CLK_DIV cycles after restart.
// No backpressure; restart_i zeroes the phase on the edge where it is sampled high.
module spi_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt <= '0;
    end else if (restart_i || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick_o = (cnt == LAST);

endmodule

// File: rtl/spi_io_ctrl.sv
// Memory-mapped mode-0 SPI master: 8-bit MSB-first transfer of 18*CLK_DIV cycles, reads have 1-cycle latency.
// No backpressure: DATA writes arriving while busy or with dev==0 are dropped and flagged as overrun.
module spi_io_ctrl
  import spi_io_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int DEV_BITS = 3
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                io_wr_ni,
  input  logic                io_rd_i,
  input  logic [1:0]          reg_addr_i,
  input  logic [7:0]          data_i,
  output logic [7:0]          rd_data_o,
  output logic                irq_o,
  output logic                busy_o,
  output logic                spi_clk,
  output logic                mosi,
  input  logic                miso,
  output logic [DEV_BITS-1:0] spi_addr
);

  spi_state_t          state;
  logic [2:0]          bit_cnt;
  logic [7:0]          shifter;
  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic                overrun;
  logic                ie;
  logic [DEV_BITS-1:0] dev;
  logic                tick;
  logic [7:0]          rd_mux;

  logic wr_en, data_wr, start, done, data_rd;

  assign wr_en   = !io_wr_ni;
  assign data_wr = wr_en && (reg_addr_i == REG_DATA);
  assign start   = data_wr && (state == ST_IDLE) && (dev != '0);
  assign done    = (state == ST_HOLD) && tick;
  assign data_rd = io_rd_i && (reg_addr_i == REG_DATA);

  assign busy_o = (state != ST_IDLE);
  assign irq_o  = rx_valid && ie;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .restart_i (start),
    .tick_o    (tick)
  );

  // The shifter doubles as tx and rx register: each rising tick shifts miso in,
  // leaving the next outgoing bit in shifter[7] for the following falling tick.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shifter  <= '0;
      spi_clk  <= 1'b0;
      mosi     <= 1'b0;
      spi_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_SETUP;
            shifter  <= data_i;
            mosi     <= data_i[7];
            spi_addr <= dev;
            spi_clk  <= 1'b0;
            bit_cnt  <= '0;
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_XFER;
        end
        ST_XFER: begin
          if (tick) begin
            if (!spi_clk) begin
              spi_clk <= 1'b1;
              shifter <= {shifter[6:0], miso};
            end else begin
              spi_clk <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= ST_HOLD;
              else                 mosi  <= shifter[7];
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state    <= ST_IDLE;
            spi_addr <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr_i)
      REG_DATA:   rd_mux = rx_byte;
      REG_CTRL: begin
        rd_mux[CTRL_DEV_LSB +: DEV_BITS] = dev;
        rd_mux[CTRL_IE]                  = ie;
      end
      REG_STATUS: rd_mux = status_byte(busy_o, rx_valid, overrun);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      dev       <= '0;
      ie        <= 1'b0;
      overrun   <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      if (wr_en && reg_addr_i == REG_CTRL) begin
        dev <= data_i[CTRL_DEV_LSB +: DEV_BITS];
        ie  <= data_i[CTRL_IE];
      end
      if (data_wr && !start)                          overrun <= 1'b1;
      else if (wr_en && reg_addr_i == REG_STATUS)     overrun <= 1'b0;
      // Completion beats a coincident DATA read; the read still sees the old byte.
      if (done) begin
        rx_byte  <= shifter;
        rx_valid <= 1'b1;
      end else if (start || data_rd) begin
        rx_valid <= 1'b0;
      end
      if (io_rd_i) rd_data_o <= rd_mux;
    end
  end

endmodule

// File: tb/tb_spi_io_ctrl.sv
// Scoreboard bench for spi_io_ctrl: a CLK_DIV=4 instance under full check and a CLK_DIV=2 twin for busy timing.
module tb_spi_io_ctrl;
  import spi_io_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       io_wr_ni = 1'b1;
  logic       io_rd_i = 1'b0;
  logic [1:0] reg_addr_i = 2'd0;
  logic [7:0] data_i = 8'd0;
  logic       miso = 1'b0;

  logic [7:0] rd_data_o, rd_data2;
  logic       irq_o, irq2, busy_o, busy2, spi_clk, spi_clk2, mosi, mosi2;
  logic [2:0] spi_addr, spi_addr2;

  spi_io_ctrl #(.CLK_DIV(4), .DEV_BITS(3)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .io_wr_ni(io_wr_ni), .io_rd_i(io_rd_i),
    .reg_addr_i(reg_addr_i), .data_i(data_i), .rd_data_o(rd_data_o), .irq_o(irq_o),
    .busy_o(busy_o), .spi_clk(spi_clk), .mosi(mosi), .miso(miso), .spi_addr(spi_addr)
  );

  spi_io_ctrl #(.CLK_DIV(2), .DEV_BITS(3)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .io_wr_ni(io_wr_ni), .io_rd_i(io_rd_i),
    .reg_addr_i(reg_addr_i), .data_i(data_i), .rd_data_o(rd_data2), .irq_o(irq2),
    .busy_o(busy2), .spi_clk(spi_clk2), .mosi(mosi2), .miso(miso), .spi_addr(spi_addr2)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] exp_mosi_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] slave_tx = 8'd0;
  logic [7:0] mosi_sh = 8'd0;
  int mosi_bits = 0;
  int spi_rise_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Collect mosi at each rising spi_clk; every 8 bits retire one expected byte.
  always @(posedge spi_clk or negedge reset_i) begin
    if (!reset_i) begin
      mosi_bits = 0;
    end else begin
      spi_rise_cnt++;
      mosi_sh = {mosi_sh[6:0], mosi};
      mosi_bits++;
      if (mosi_bits == 8) begin
        mosi_bits = 0;
        check_val("mosi_pending", exp_mosi_q.size() != 0, 1);
        if (exp_mosi_q.size() != 0) check_val("mosi_byte", mosi_sh, exp_mosi_q.pop_front());
      end
    end
  end

  // Mode-0 slave: next bit presented on each falling spi_clk.
  always @(negedge spi_clk) begin
    slave_tx = slave_tx << 1;
    miso = slave_tx[7];
  end

  task automatic set_slave(input logic [7:0] b);
    slave_tx = b;
    miso = b[7];
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk_i);
    io_wr_ni = 1'b0; reg_addr_i = a; data_i = d;
    @(negedge clk_i);
    io_wr_ni = 1'b1;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] v);
    @(negedge clk_i);
    io_rd_i = 1'b1; reg_addr_i = a;
    @(negedge clk_i);
    io_rd_i = 1'b0;
    v = rd_data_o;
  endtask

  task automatic pop_rd(input string tag, input logic [7:0] v);
    check_val("rd_pending", exp_rd_q.size() != 0, 1);
    if (exp_rd_q.size() != 0) check_val(tag, v, exp_rd_q.pop_front());
  endtask

  task automatic read_data(input string tag);
    logic [7:0] v;
    cpu_rd(REG_DATA, v);
    pop_rd(tag, v);
  endtask

  task automatic wait_idle(input string tag);
    bit ended = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy_o) begin ended = 1; break; end
      @(negedge clk_i);
    end
    check_val(tag, ended, 1);
  endtask

  task automatic xfer(input logic [7:0] tx, input logic [7:0] rx, input logic [2:0] dev_exp);
    int nb = 0, na = 0, nb2 = 0, nirq = 0;
    bit ended = 0;
    set_slave(rx);
    exp_mosi_q.push_back(tx);
    exp_rd_q.push_back(rx);
    cpu_wr(REG_DATA, tx);
    for (int i = 0; i < 200; i++) begin
      if (!busy_o) begin ended = 1; break; end
      nb++;
      if (spi_addr == dev_exp) na++;
      if (busy2) nb2++;
      if (irq_o) nirq++;
      @(negedge clk_i);
    end
    check_val("xfer_done", ended, 1);
    check_val("busy_cycles", nb, 72);
    check_val("addr_cycles", na, 72);
    check_val("busy_cycles_div2", nb2, 36);
    check_val("irq_while_busy", nirq, 0);
    check_val("spi_addr_after", spi_addr, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int r, nb;

    repeat (3) @(negedge clk_i);
    check_val("rst_rd_data", rd_data_o, 0);
    check_val("rst_irq", irq_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_pins", {spi_clk, mosi, spi_addr}, 0);
    reset_i = 1'b1;
    cpu_rd(REG_STATUS, v); check_val("rst_status", v, 8'h00);
    cpu_rd(REG_CTRL, v);   check_val("rst_ctrl", v, 8'h00);

    // Basic transfer
    cpu_wr(REG_CTRL, 8'h01);
    xfer(8'hA5, 8'h3C, 3'd1);
    cpu_rd(REG_STATUS, v); check_val("basic_status", v, 8'h02);
    read_data("basic_rx");
    cpu_rd(REG_STATUS, v); check_val("basic_status_clr", v, 8'h00);

    // Interrupt, reserved CTRL bits dropped
    cpu_wr(REG_CTRL, 8'hFA);
    cpu_rd(REG_CTRL, v); check_val("ctrl_readback", v, 8'h0A);
    xfer(8'hFF, 8'h81, 3'd2);
    check_val("irq_at_done", irq_o, 1);
    read_data("irq_rx");
    check_val("irq_after_read", irq_o, 0);

    // Overrun while busy
    cpu_wr(REG_CTRL, 8'h01);
    set_slave(8'h7E);
    exp_mosi_q.push_back(8'h55);
    exp_rd_q.push_back(8'h7E);
    cpu_wr(REG_DATA, 8'h55);
    repeat (9) @(negedge clk_i);
    cpu_wr(REG_DATA, 8'h99);
    wait_idle("ovr_idle");
    cpu_rd(REG_STATUS, v); check_val("ovr_status", v, 8'h06);
    cpu_wr(REG_STATUS, 8'h00);
    cpu_rd(REG_STATUS, v); check_val("ovr_cleared", v, 8'h02);
    read_data("ovr_rx");

    // dev = 0
    cpu_wr(REG_CTRL, 8'h00);
    r = spi_rise_cnt;
    nb = 0;
    cpu_wr(REG_DATA, 8'h12);
    repeat (100) begin
      if (busy_o) nb++;
      @(negedge clk_i);
    end
    check_val("dev0_busy", nb, 0);
    check_val("dev0_sclk_edges", spi_rise_cnt, r);
    cpu_rd(REG_STATUS, v); check_val("dev0_status", v, 8'h04);
    cpu_wr(REG_STATUS, 8'h00);
    cpu_rd(REG_STATUS, v); check_val("dev0_status_clr", v, 8'h00);

    // Reset mid-transfer, while spi_clk and mosi are both high
    cpu_wr(REG_CTRL, 8'h03);
    set_slave(8'hFF);
    cpu_wr(REG_DATA, 8'hF0);
    repeat (32) @(negedge clk_i);
    check_val("pre_rst_pins", {spi_clk, mosi, spi_addr, busy_o}, {1'b1, 1'b1, 3'd3, 1'b1});
    #2 reset_i = 1'b0;
    #1;
    check_val("arst_sclk", spi_clk, 0);
    check_val("arst_mosi", mosi, 0);
    check_val("arst_addr", spi_addr, 0);
    check_val("arst_busy", busy_o, 0);
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    cpu_rd(REG_STATUS, v); check_val("arst_status", v, 8'h00);
    cpu_rd(REG_CTRL, v);   check_val("arst_ctrl", v, 8'h00);
    cpu_wr(REG_CTRL, 8'h03);
    xfer(8'h6E, 8'h91, 3'd3);
    read_data("post_rst_rx");

    // DATA read in the completion cycle
    cpu_wr(REG_CTRL, 8'h01);
    exp_rd_q.push_back(8'h91);
    set_slave(8'h5A);
    exp_mosi_q.push_back(8'hB7);
    exp_rd_q.push_back(8'h5A);
    cpu_wr(REG_DATA, 8'hB7);
    repeat (71) @(negedge clk_i);
    check_val("pre_done_busy", busy_o, 1);
    io_rd_i = 1'b1; reg_addr_i = REG_DATA;
    @(negedge clk_i);
    io_rd_i = 1'b0;
    check_val("done_busy", busy_o, 0);
    pop_rd("rd_at_done", rd_data_o);
    cpu_rd(REG_STATUS, v); check_val("rxv_after_race", v, 8'h02);
    read_data("race_rx");
    cpu_rd(REG_STATUS, v); check_val("race_status_clr", v, 8'h00);

    check_val("mosi_q_drained", exp_mosi_q.size(), 0);
    check_val("rd_q_drained", exp_rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
